// File: rtl/mem_copier_if.sv
// mem_copier_if -- request, status and memory-port signals of mem_copier.
//   start/src/dst/len : copy request (requester -> copier)
//   busy/done/err     : copier status
//   readad/rdata      : synchronous-read memory port, rdata one cycle after readad
//   writead/wdata/memwrite : memory write port
// slave = the copier; master = requester plus memory.
interface mem_copier_if;
  logic        start;
  logic [11:0] src;
  logic [11:0] dst;
  logic [11:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic [11:0] readad;
  logic [11:0] rdata;
  logic [11:0] writead;
  logic [11:0] wdata;
  logic        memwrite;

  modport slave (
    input  start, src, dst, len, rdata,
    output busy, done, err, readad, writead, wdata, memwrite
  );

  modport master (
    output start, src, dst, len, rdata,
    input  busy, done, err, readad, writead, wdata, memwrite
  );
endinterface

// File: rtl/mem_copier.sv
// mem_copier -- copies len words from src to dst, one word every two cycles
// (READ presents the source address, WRITE stores the returned word).
// Requests running past address 4095 or reaching MAP_LIMIT are rejected
// without touching memory and flag err until the next accepted start.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-low reset
//   bus : mem_copier_if.slave (request, status, memory port)
module mem_copier #(
  parameter int unsigned MAP_LIMIT = 4000
) (
  input  logic         clk,
  input  logic         rst,
  mem_copier_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [12:0] LIMIT = 13'(MAP_LIMIT);
  localparam logic [12:0] TOP   = 13'd4095;

  logic [1:0]  state_q, state_d;
  logic [11:0] src_ptr_q, src_ptr_d;
  logic [11:0] dst_ptr_q, dst_ptr_d;
  logic [11:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  // Last addresses touched, computed in 13 bits so a run past 4095 is visible.
  logic [12:0] src_end, dst_end;
  logic        reject;

  assign src_end = {1'b0, bus.src} + {1'b0, bus.len} - 13'd1;
  assign dst_end = {1'b0, bus.dst} + {1'b0, bus.len} - 13'd1;
  assign reject  = (bus.len != '0) &&
                   ((src_end > TOP) || (dst_end > TOP) ||
                    (src_end >= LIMIT) || (dst_end >= LIMIT));

  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          src_ptr_d = bus.src;
          dst_ptr_d = bus.dst;
          cnt_d     = bus.len;
          err_d     = 1'b0;
          if (bus.len == '0) begin
            state_d = DONE;
          end else if (reject) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: state_d = WRITE;
      WRITE: begin
        src_ptr_d = src_ptr_q + 12'd1;
        dst_ptr_d = dst_ptr_q + 12'd1;
        cnt_d     = cnt_q - 12'd1;
        state_d   = (cnt_q == 12'd1) ? DONE : READ;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Outputs are pure state decodes, so reset forces them all to zero.
  assign bus.busy     = (state_q == READ) || (state_q == WRITE);
  assign bus.done     = (state_q == DONE);
  assign bus.err      = err_q;
  assign bus.readad   = (state_q == READ)  ? src_ptr_q : '0;
  assign bus.writead  = (state_q == WRITE) ? dst_ptr_q : '0;
  assign bus.wdata    = (state_q == WRITE) ? bus.rdata : '0;
  assign bus.memwrite = (state_q == WRITE);

endmodule

// File: tb/tb_mem_copier.sv
// tb_mem_copier -- randomized and directed copies checked against a
// word-array reference of the memory and timing rules of mem_copier.
module tb_mem_copier;
  localparam int MAP_LIMIT = 4000;

  logic clk;
  logic rst;
  mem_copier_if bus ();

  mem_copier #(.MAP_LIMIT(MAP_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory attached to the copier, plus a preload port.
  logic [11:0] mem [4096];
  logic [11:0] ref_mem [4096];
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [11:0] pre_data;

  always @(posedge clk) begin
    bus.rdata <= mem[bus.readad];
    if (bus.memwrite) mem[bus.writead] <= bus.wdata;
    else if (pre_we)  mem[pre_addr]    <= pre_data;
  end

  int n_checks = 0;
  int n_errors = 0;
  bit exp_err  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic preload(input int a, input int v);
    pre_we   = 1'b1;
    pre_addr = 12'(a);
    pre_data = 12'(v);
    ref_mem[a] = 12'(v);
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) mism++;
    check_eq(tag, 32'(mism), 32'd0);
  endtask

  // One request from a negedge; returns on a negedge after the done pulse.
  task automatic run_copy(input int s, input int d, input int n, input bit poke);
    bit rej, seen;
    int k, lat_exp, writes, busys, stray;
    rej = (n != 0) && ((s + n - 1 > 4095) || (d + n - 1 > 4095) ||
                       (s + n - 1 >= MAP_LIMIT) || (d + n - 1 >= MAP_LIMIT));
    lat_exp = (n == 0 || rej) ? 1 : 2 * n + 1;
    check_eq("err_hold", 32'(bus.err), 32'(exp_err));
    bus.start = 1'b1;
    bus.src = 12'(s);
    bus.dst = 12'(d);
    bus.len = 12'(n);
    k = 0; seen = 1'b0; writes = 0; busys = 0; stray = 0;
    while (!seen && k < 2 * n + 8) begin
      @(negedge clk);
      k++;
      if (bus.memwrite) writes++;
      if (bus.busy) busys++;
      if (!bus.memwrite && (bus.writead != 12'd0 || bus.wdata != 12'd0)) stray++;
      if ((!bus.busy || bus.memwrite) && bus.readad != 12'd0) stray++;
      if (bus.done) seen = 1'b1;
      // A start arriving mid-copy must be ignored.
      bus.start = poke && (k == 2);
      if (poke && k == 2) begin
        bus.src = 12'($urandom_range(0, 4095));
        bus.dst = 12'($urandom_range(0, 4095));
        bus.len = 12'($urandom_range(0, 4095));
      end
    end
    bus.start = 1'b0;
    check_eq("done_seen", 32'(seen), 32'd1);
    check_eq("done_lat", 32'(k), 32'(lat_exp));
    check_eq("writes", 32'(writes), (n == 0 || rej) ? 32'd0 : 32'(n));
    check_eq("busy_cycles", 32'(busys), (n == 0 || rej) ? 32'd0 : 32'(2 * n));
    check_eq("stray_outs", 32'(stray), 32'd0);
    check_eq("err", 32'(bus.err), 32'(rej));
    @(negedge clk);
    check_eq("done_width", 32'(bus.done), 32'd0);
    if (!rej) for (int i = 0; i < n; i++) ref_mem[d + i] = ref_mem[s + i];
    check_mem("mem");
    exp_err = rej;
  endtask

  task automatic reset_mid_copy(input int s, input int d);
    int dones, writes;
    dones = 0; writes = 0;
    bus.start = 1'b1; bus.src = 12'(s); bus.dst = 12'(d); bus.len = 12'd4;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) dones++;
    end
    rst = 1'b0;  // second READ cycle
    @(negedge clk);
    check_eq("abort_outs",
             32'({bus.busy, bus.done, bus.err, bus.memwrite, bus.readad, bus.writead, bus.wdata}),
             32'd0);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.memwrite) writes++;
    end
    check_eq("abort_no_done", 32'(dones), 32'd0);
    check_eq("abort_no_write", 32'(writes), 32'd0);
    ref_mem[d] = ref_mem[s];
    check_mem("abort_mem");
    exp_err = 1'b0;
  endtask

  initial begin
    int s, d, n;
    rst = 1'b0;
    bus.start = 1'b0; bus.src = '0; bus.dst = '0; bus.len = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    for (int i = 0; i < 4096; i++) preload(i, int'($urandom_range(0, 4095)));
    check_eq("reset_outs",
             32'({bus.busy, bus.done, bus.err, bus.memwrite, bus.readad, bus.writead, bus.wdata}),
             32'd0);
    rst = 1'b1;
    @(negedge clk);

    preload(10, 5); preload(11, 6); preload(12, 7);
    run_copy(10, 20, 3, 1'b0);
    check_eq("m20", 32'(mem[20]), 32'd5);
    check_eq("m21", 32'(mem[21]), 32'd6);
    check_eq("m22", 32'(mem[22]), 32'd7);

    run_copy(100, 200, 0, 1'b0);
    run_copy(3998, 0, 5, 1'b0);
    run_copy(0, 50, 2, 1'b0);
    run_copy(4090, 0, 10, 1'b0);
    run_copy(0, 3999, 1, 1'b0);
    run_copy(3999, 0, 1, 1'b0);
    run_copy(0, 3995, 5, 1'b0);
    run_copy(40, 60, 4, 1'b1);
    reset_mid_copy(70, 80);

    preload(30, 1); preload(31, 2); preload(32, 3);
    run_copy(30, 31, 3, 1'b0);
    check_eq("m31", 32'(mem[31]), 32'd1);
    check_eq("m33", 32'(mem[33]), 32'd1);

    // Reset and start on the same edge: request dropped.
    rst = 1'b0; bus.start = 1'b1; bus.src = 12'd5; bus.dst = 12'd500; bus.len = 12'd3;
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.busy || bus.done || bus.memwrite) n++;
    end
    check_eq("rst_wins", 32'(n), 32'd0);
    check_mem("rst_wins_mem");

    for (int it = 0; it < 24; it++) begin
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3980, 4095)) : int'($urandom_range(0, 3900));
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3980, 4095)) : int'($urandom_range(0, 3900));
      n = int'($urandom_range(0, 12));
      if ($urandom_range(0, 7) == 0) n = int'($urandom_range(100, 4095));
      run_copy(s, d, n, $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
